// File: rtl/uart_prog_loader_if.sv
// ============================================================================
//  Module      : uart_prog_loader_if
//  Description : Instruction-memory write port and loader status signals
//                shared between the UART program loader and its consumers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_prog_loader_if #(
    parameter int ADDR_W = 14
);
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic              core_rst_l_o;
    logic              prog_done_o;
    logic              frame_err_o;

    // Loader side drives the memory write and status signals
    modport master (
        output mem_we_o,
        output mem_addr_o,
        output mem_wdata_o,
        output core_rst_l_o,
        output prog_done_o,
        output frame_err_o
    );

    // Memory / core side observes them
    modport slave (
        input  mem_we_o,
        input  mem_addr_o,
        input  mem_wdata_o,
        input  core_rst_l_o,
        input  prog_done_o,
        input  frame_err_o
    );
endinterface

`default_nettype wire

// File: rtl/uart_prog_loader.sv
// ============================================================================
//  Module      : uart_prog_loader
//  Description : Receives a program over UART (8N1, LSB first), packs bytes
//                little-endian into 32-bit words and writes them to
//                consecutive instruction-memory addresses. The terminator
//                word releases the core reset and freezes the loader.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_prog_loader #(
    parameter int          CLKS_PER_BIT = 347,
    parameter int          ADDR_W       = 14,
    parameter logic [31:0] END_WORD     = 32'hFFFF_FFFF
) (
    input  wire logic           clk,
    input  wire logic           rst_l,
    input  wire logic           rx_serial_i,
    uart_prog_loader_if.master  bus
);

    localparam int                 c_CNT_W     = $clog2(CLKS_PER_BIT + 1);
    localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    logic               r_rx_meta;
    logic               r_rx_sync;
    state_t             r_state;
    logic [c_CNT_W-1:0] r_clk_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic [1:0]         r_byte_cnt;
    logic [23:0]        r_word;
    logic               r_brk_wait;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [31:0]        r_mem_wdata;
    logic               r_core_rst_l;
    logic               r_prog_done;
    logic               r_frame_err;
    logic [31:0]        w_word;

    // Completed word once the fourth byte has just been shifted in
    assign w_word = {r_shift, r_word};

    // Two-flop synchronizer for the asynchronous receive line (idles high)
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx_serial_i;
            r_rx_sync <= r_rx_meta;
        end
    end

    // Receive FSM, byte/word assembly and registered memory/status outputs
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state      <= ST_IDLE;
            r_clk_cnt    <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_byte_cnt   <= '0;
            r_word       <= '0;
            r_brk_wait   <= 1'b0;
            r_addr       <= '0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_core_rst_l <= 1'b0;
            r_prog_done  <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            // After the terminator the loader is frozen until the next reset
            if (!r_prog_done) begin
                case (r_state)
                    ST_IDLE: begin
                        if (!r_rx_sync) begin
                            r_state   <= ST_START;
                            r_clk_cnt <= '0;
                            r_bit_idx <= '0;
                        end
                    end
                    ST_START: begin
                        // Re-check mid start bit; a high line means a glitch
                        if (r_clk_cnt == c_HALF_LAST) begin
                            r_clk_cnt <= '0;
                            r_state   <= r_rx_sync ? ST_IDLE : ST_DATA;
                        end else begin
                            r_clk_cnt <= r_clk_cnt + 1'b1;
                        end
                    end
                    ST_DATA: begin
                        if (r_clk_cnt == c_BIT_LAST) begin
                            r_clk_cnt <= '0;
                            r_shift   <= {r_rx_sync, r_shift[7:1]};
                            r_bit_idx <= r_bit_idx + 3'd1;
                            if (r_bit_idx == 3'd7) begin
                                r_state <= ST_STOP;
                            end
                        end else begin
                            r_clk_cnt <= r_clk_cnt + 1'b1;
                        end
                    end
                    ST_STOP: begin
                        if (r_brk_wait) begin
                            // Framing error: hold off until the line is idle again
                            if (r_rx_sync) begin
                                r_brk_wait <= 1'b0;
                                r_state    <= ST_IDLE;
                            end
                        end else if (r_clk_cnt == c_BIT_LAST) begin
                            r_clk_cnt <= '0;
                            if (r_rx_sync) begin
                                r_state    <= ST_IDLE;
                                r_byte_cnt <= r_byte_cnt + 2'd1;
                                case (r_byte_cnt)
                                    2'd0:    r_word[7:0]   <= r_shift;
                                    2'd1:    r_word[15:8]  <= r_shift;
                                    2'd2:    r_word[23:16] <= r_shift;
                                    default: r_word        <= r_word;
                                endcase
                                if (r_byte_cnt == 2'd3) begin
                                    if (w_word == END_WORD) begin
                                        r_prog_done  <= 1'b1;
                                        r_core_rst_l <= 1'b1;
                                    end else begin
                                        r_mem_we    <= 1'b1;
                                        r_mem_wdata <= w_word;
                                        r_mem_addr  <= r_addr;
                                        r_addr      <= r_addr + 1'b1;
                                    end
                                end
                            end else begin
                                r_frame_err <= 1'b1;
                                r_brk_wait  <= 1'b1;
                            end
                        end else begin
                            r_clk_cnt <= r_clk_cnt + 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.mem_we_o     = r_mem_we;
    assign bus.mem_addr_o   = r_mem_addr;
    assign bus.mem_wdata_o  = r_mem_wdata;
    assign bus.core_rst_l_o = r_core_rst_l;
    assign bus.prog_done_o  = r_prog_done;
    assign bus.frame_err_o  = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_uart_prog_loader.sv
// ============================================================================
//  Module      : tb_uart_prog_loader
//  Description : Scoreboard bench for uart_prog_loader. UART frames are
//                driven bit by bit; expected memory writes are queued as the
//                stimulus is issued and a monitor checks every write strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_prog_loader;

    localparam int CLKS   = 16;
    localparam int HALF   = CLKS / 2;
    localparam int ADDR_W = 2;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic clk      = 1'b0;
    logic rst_l    = 1'b0;
    logic rx_line  = 1'b1;
    wr_t  sb_q[$];
    int   n_pass   = 0;
    int   n_total  = 0;

    uart_prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

    uart_prog_loader #(
        .CLKS_PER_BIT (CLKS),
        .ADDR_W       (ADDR_W),
        .END_WORD     (32'hFFFF_FFFF)
    ) dut (
        .clk         (clk),
        .rst_l       (rst_l),
        .rx_serial_i (rx_line),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%h required=%h", name, act, exp);
    endtask

    // Pops one expected write per strobe seen on the memory port
    task automatic monitor();
        wr_t e;
        forever begin
            @(negedge clk);
            if (bus.mem_we_o === 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_write", {31'd0, bus.mem_we_o}, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("write_addr", {30'd0, bus.mem_addr_o}, {30'd0, e.addr});
                    chk("write_data", bus.mem_wdata_o, e.data);
                end
            end
        end
    endtask

    task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        sb_q.push_back({a, d});
    endtask

    // One 8N1 frame; with chk_done the edge of the stop-bit sample is checked
    task automatic send_byte(input logic [7:0] b, input bit good_stop, input bit chk_done);
        @(posedge clk);
        #1 rx_line = 1'b0;
        repeat (CLKS) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rx_line = b[i];
            repeat (CLKS) @(posedge clk);
        end
        #1 rx_line = good_stop;
        if (chk_done) begin
            repeat (2 + HALF) @(posedge clk);
            @(negedge clk);
            chk("done_before_stop_sample", {31'd0, bus.prog_done_o}, 32'd0);
            chk("core_rst_before_stop_sample", {31'd0, bus.core_rst_l_o}, 32'd0);
            @(posedge clk);
            @(negedge clk);
            chk("done_after_stop_sample", {31'd0, bus.prog_done_o}, 32'd1);
            chk("core_rst_after_stop_sample", {31'd0, bus.core_rst_l_o}, 32'd1);
            repeat (CLKS - 3 - HALF) @(posedge clk);
        end else begin
            repeat (CLKS) @(posedge clk);
        end
        if (!good_stop) begin
            #1 rx_line = 1'b1;
            repeat (CLKS) @(posedge clk);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit chk_done);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8], 1'b1, chk_done && (k == 3));
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_l = 1'b0;
        rx_line = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_we",       {31'd0, bus.mem_we_o},     32'd0);
        chk("rst_addr",     {30'd0, bus.mem_addr_o},   32'd0);
        chk("rst_wdata",    bus.mem_wdata_o,           32'd0);
        chk("rst_core_rst", {31'd0, bus.core_rst_l_o}, 32'd0);
        chk("rst_done",     {31'd0, bus.prog_done_o},  32'd0);
        chk("rst_frame",    {31'd0, bus.frame_err_o},  32'd0);
        @(posedge clk);
        #1 rst_l = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        fork
            monitor();
        join_none

        // Single word, with a long idle gap mid-word to show no timeout
        do_reset();
        expect_write(2'd0, 32'h0000_0013);
        send_byte(8'h13, 1'b1, 1'b0);
        send_byte(8'h00, 1'b1, 1'b0);
        repeat (40 * CLKS) @(posedge clk);
        send_byte(8'h00, 1'b1, 1'b0);
        send_byte(8'h00, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("t1_core_rst_low", {31'd0, bus.core_rst_l_o}, 32'd0);
        chk("t1_done_low",     {31'd0, bus.prog_done_o},  32'd0);
        chk("t1_sb_drained",   sb_q.size(), 32'd0);

        // Two words, then terminator; later traffic is ignored
        do_reset();
        expect_write(2'd0, 32'h0000_0093);
        send_word(32'h0000_0093, 1'b0);
        expect_write(2'd1, 32'h0010_0113);
        send_word(32'h0010_0113, 1'b0);
        send_word(32'hFFFF_FFFF, 1'b1);
        send_word(32'h5566_7788, 1'b0);
        send_byte(8'h12, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("t2_done_sticky",  {31'd0, bus.prog_done_o},  32'd1);
        chk("t2_core_rst_hi",  {31'd0, bus.core_rst_l_o}, 32'd1);
        chk("t2_frame_frozen", {31'd0, bus.frame_err_o},  32'd0);
        chk("t2_sb_drained",   sb_q.size(), 32'd0);

        // Framing error, then a clean word at address 0
        do_reset();
        send_byte(8'h5A, 1'b0, 1'b0);
        @(negedge clk);
        chk("t3_frame_err", {31'd0, bus.frame_err_o}, 32'd1);
        expect_write(2'd0, 32'h4433_2211);
        send_word(32'h4433_2211, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("t3_frame_sticky", {31'd0, bus.frame_err_o}, 32'd1);
        chk("t3_sb_drained",   sb_q.size(), 32'd0);

        // Short low glitch on an idle line is rejected
        do_reset();
        @(posedge clk);
        #1 rx_line = 1'b0;
        repeat (5) @(posedge clk);
        #1 rx_line = 1'b1;
        repeat (3 * CLKS) @(posedge clk);
        @(negedge clk);
        chk("t4_no_frame_err", {31'd0, bus.frame_err_o}, 32'd0);
        chk("t4_no_write",     sb_q.size(), 32'd0);
        expect_write(2'd0, 32'hA5C3_0F81);
        send_word(32'hA5C3_0F81, 1'b0);
        repeat (4) @(posedge clk);
        chk("t4_sb_drained", sb_q.size(), 32'd0);

        // Address wraps with a 2-bit address space
        do_reset();
        expect_write(2'd0, 32'h0000_0001);
        send_word(32'h0000_0001, 1'b0);
        expect_write(2'd1, 32'h0000_0002);
        send_word(32'h0000_0002, 1'b0);
        expect_write(2'd2, 32'h0000_0003);
        send_word(32'h0000_0003, 1'b0);
        expect_write(2'd3, 32'h0000_0004);
        send_word(32'h0000_0004, 1'b0);
        expect_write(2'd0, 32'h0000_0005);
        send_word(32'h0000_0005, 1'b0);
        repeat (4) @(posedge clk);
        chk("t5_sb_drained", sb_q.size(), 32'd0);

        // Reset mid-word discards partial data
        do_reset();
        send_byte(8'h01, 1'b1, 1'b0);
        send_byte(8'h02, 1'b1, 1'b0);
        @(posedge clk);
        #1 rx_line = 1'b0;
        repeat (3 * CLKS) @(posedge clk);
        do_reset();
        expect_write(2'd0, 32'hDDCC_BBAA);
        send_byte(8'hAA, 1'b1, 1'b0);
        send_byte(8'hBB, 1'b1, 1'b0);
        send_byte(8'hCC, 1'b1, 1'b0);
        send_byte(8'hDD, 1'b1, 1'b0);
        repeat (10) @(posedge clk);
        chk("t6_sb_drained", sb_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
